// File: rtl/cache_ctrl.sv
// Direct-mapped write-back/write-allocate cache, 64 one-word lines; hit data_rdy 2 cycles after sampling, misses add memory time.
// Requests are sampled only in IDLE; memory ops hold mem_en until mem_op_finish, stalling the CPU indefinitely.
module cache_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic        rd,
    input  logic        wr,
    input  logic [31:0] input_data,
    output logic [31:0] output_data,
    output logic        data_rdy,
    input  logic [31:0] mem_rd_data,
    output logic [31:0] mem_addr,
    output logic [31:0] wr_to_mem,
    output logic        mem_rw,
    output logic        mem_en,
    input  logic        mem_op_finish
);

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        DONE
    } state_t;

    state_t      state;
    logic [31:2] req_addr;
    logic [31:0] req_data;
    logic        req_wr;

    logic [63:0] valid;
    logic [63:0] dirty;
    logic [23:0] tag_mem  [64];
    logic [31:0] data_mem [64];

    logic [5:0]  idx;
    logic [23:0] req_tag;
    logic [23:0] victim_tag;
    logic [31:0] line_data;
    logic        hit;

    logic        line_wr_en;
    logic        line_tag_wr;
    logic [31:0] line_wr_data;

    // Word access only: the byte offset plays no part in lookup or memory addressing.
    logic        unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    assign idx        = req_addr[7:2];
    assign req_tag    = req_addr[31:8];
    assign victim_tag = tag_mem[idx];
    assign line_data  = data_mem[idx];
    assign hit        = valid[idx] && (victim_tag == req_tag);

    always_comb begin
        line_wr_en   = 1'b0;
        line_tag_wr  = 1'b0;
        line_wr_data = '0;
        if (state == COMPARE && hit && req_wr) begin
            line_wr_en   = 1'b1;
            line_wr_data = req_data;
        end else if (state == ALLOCATE && mem_op_finish) begin
            line_wr_en   = 1'b1;
            line_tag_wr  = 1'b1;
            line_wr_data = mem_rd_data;
        end
    end

    // Line storage needs no reset: valid bits gate every use of it.
    always_ff @(posedge clk) begin
        if (line_wr_en) begin
            data_mem[idx] <= line_wr_data;
        end
        if (line_tag_wr) begin
            tag_mem[idx] <= req_tag;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            req_addr    <= '0;
            req_data    <= '0;
            req_wr      <= 1'b0;
            valid       <= '0;
            dirty       <= '0;
            output_data <= '0;
            data_rdy    <= 1'b0;
            mem_addr    <= '0;
            wr_to_mem   <= '0;
            mem_rw      <= 1'b0;
            mem_en      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd || wr) begin
                        req_addr <= addr[31:2];
                        req_data <= input_data;
                        req_wr   <= wr;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (hit) begin
                        if (req_wr) begin
                            dirty[idx] <= 1'b1;
                        end else begin
                            output_data <= line_data;
                        end
                        data_rdy <= 1'b1;
                        state    <= DONE;
                    end else if (valid[idx] && dirty[idx]) begin
                        mem_en    <= 1'b1;
                        mem_rw    <= 1'b1;
                        mem_addr  <= {victim_tag, idx, 2'b00};
                        wr_to_mem <= line_data;
                        state     <= WRITEBACK;
                    end else begin
                        mem_en    <= 1'b1;
                        mem_rw    <= 1'b0;
                        mem_addr  <= {req_addr, 2'b00};
                        wr_to_mem <= '0;
                        state     <= ALLOCATE;
                    end
                end
                WRITEBACK: begin
                    if (mem_op_finish) begin
                        mem_rw    <= 1'b0;
                        mem_addr  <= {req_addr, 2'b00};
                        wr_to_mem <= '0;
                        state     <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (mem_op_finish) begin
                        valid[idx] <= 1'b1;
                        dirty[idx] <= 1'b0;
                        mem_en     <= 1'b0;
                        mem_rw     <= 1'b0;
                        mem_addr   <= '0;
                        wr_to_mem  <= '0;
                        state      <= COMPARE;
                    end
                end
                DONE: begin
                    data_rdy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl: synchronous requester on negedges plus a fixed-delay memory responder.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] input_data;
    logic [31:0] output_data;
    logic        data_rdy;
    logic [31:0] mem_rd_data;
    logic [31:0] mem_addr;
    logic [31:0] wr_to_mem;
    logic        mem_rw;
    logic        mem_en;
    logic        mem_op_finish;

    int          n_vec = 0;
    int          n_err = 0;

    logic        hold_mem = 1'b0;
    logic [31:0] mem_ret  = '0;
    int          wait_cnt = 0;
    int          mem_en_cycles = 0;
    int          idle_viol = 0;
    logic        log_rw[$];
    logic [31:0] log_addr[$];
    logic [31:0] log_wdata[$];

    int          lat;
    logic [31:0] rdata;

    cache_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .addr          (addr),
        .rd            (rd),
        .wr            (wr),
        .input_data    (input_data),
        .output_data   (output_data),
        .data_rdy      (data_rdy),
        .mem_rd_data   (mem_rd_data),
        .mem_addr      (mem_addr),
        .wr_to_mem     (wr_to_mem),
        .mem_rw        (mem_rw),
        .mem_en        (mem_en),
        .mem_op_finish (mem_op_finish)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: answers every request two negedges after it sees mem_en, unless held.
    initial begin
        mem_op_finish = 1'b0;
        mem_rd_data   = '0;
        forever begin
            @(negedge clk);
            if (mem_en) mem_en_cycles++;
            if (!mem_en && (mem_addr != 0 || wr_to_mem != 0 || mem_rw)) idle_viol++;
            if (mem_op_finish) begin
                mem_op_finish = 1'b0;
                wait_cnt      = 0;
            end else if (mem_en && !hold_mem) begin
                if (wait_cnt == 2) begin
                    log_rw.push_back(mem_rw);
                    log_addr.push_back(mem_addr);
                    log_wdata.push_back(wr_to_mem);
                    mem_rd_data   = mem_ret;
                    mem_op_finish = 1'b1;
                    wait_cnt      = 0;
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Called at a negedge. lat counts rising edges from the sampling edge up to the edge that captures data_rdy.
    task automatic cpu_op(input logic do_rd, input logic do_wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] ret,
                          output int lat_o, output logic [31:0] rdata_o);
        logic seen;
        logic got;
        log_rw.delete();
        log_addr.delete();
        log_wdata.delete();
        mem_en_cycles = 0;
        mem_ret    = ret;
        rd         = do_rd;
        wr         = do_wr;
        addr       = a;
        input_data = d;
        lat_o      = 0;
        rdata_o    = '0;
        got        = 1'b0;
        for (int i = 0; i < 200 && !got; i++) begin
            seen    = data_rdy;
            rdata_o = output_data;
            @(posedge clk);
            lat_o++;
            if (seen) got = 1'b1;
            else @(negedge clk);
        end
        chk($sformatf("done_%08h", a), {31'd0, got}, 32'd1);
        @(negedge clk);
        rd = 1'b0;
        wr = 1'b0;
        chk("rdy_one_cycle", {31'd0, data_rdy}, 32'd0);
    endtask

    initial begin
        int lost;
        int rdy_cnt;
        rst_n      = 1'b0;
        rd         = 1'b0;
        wr         = 1'b0;
        addr       = '0;
        input_data = '0;
        repeat (3) @(negedge clk);
        chk("rst_output_data", output_data, 32'd0);
        chk("rst_data_rdy", {31'd0, data_rdy}, 32'd0);
        chk("rst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write miss to an empty cache: allocate only, then the write lands in the line.
        cpu_op(1'b0, 1'b1, 32'h0, 32'd100, 32'd5, lat, rdata);
        chk("w0_nmem", log_rw.size(), 32'd1);
        chk("w0_rw", {31'd0, log_rw[0]}, 32'd0);
        chk("w0_addr", log_addr[0], 32'h0);
        chk("w0_outdata_kept", output_data, 32'd0);

        cpu_op(1'b0, 1'b1, 32'h4, 32'd200, 32'hDEAD, lat, rdata);
        cpu_op(1'b0, 1'b1, 32'h8, 32'd300, 32'hDEAD, lat, rdata);
        cpu_op(1'b0, 1'b1, 32'hC, 32'd400, 32'hDEAD, lat, rdata);
        chk("wC_addr", log_addr[0], 32'hC);

        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            cpu_op(1'b1, 1'b0, a, 32'd0, 32'hBAD, lat, rdata);
            chk($sformatf("hit_data_%0d", i), rdata, 32'(100 * (i + 1)));
            chk($sformatf("hit_lat_%0d", i), lat, 32'd3);
            chk($sformatf("hit_nomem_%0d", i), mem_en_cycles, 32'd0);
        end

        // Conflicting write evicts dirty line 0 first.
        cpu_op(1'b0, 1'b1, 32'h100, 32'd1700, 32'd9, lat, rdata);
        chk("wb_nmem", log_rw.size(), 32'd2);
        chk("wb_rw", {31'd0, log_rw[0]}, 32'd1);
        chk("wb_addr", log_addr[0], 32'h0);
        chk("wb_data", log_wdata[0], 32'd100);
        chk("wb_alloc_rw", {31'd0, log_rw[1]}, 32'd0);
        chk("wb_alloc_addr", log_addr[1], 32'h100);
        cpu_op(1'b1, 1'b0, 32'h100, 32'd0, 32'hBAD, lat, rdata);
        chk("rd100_data", rdata, 32'd1700);
        chk("rd100_lat", lat, 32'd3);
        cpu_op(1'b1, 1'b0, 32'h0, 32'd0, 32'd55, lat, rdata);
        chk("ev1700_addr", log_addr[0], 32'h100);
        chk("ev1700_data", log_wdata[0], 32'd1700);
        chk("ev1700_rdata", rdata, 32'd55);

        // Clean miss: allocate only.
        cpu_op(1'b1, 1'b0, 32'h0030_0184, 32'd0, 32'h1234, lat, rdata);
        chk("clean_nmem", log_rw.size(), 32'd1);
        chk("clean_rw", {31'd0, log_rw[0]}, 32'd0);
        chk("clean_addr", log_addr[0], 32'h0030_0184);
        chk("clean_rdata", rdata, 32'h1234);

        // Stalled allocate, then reset mid-request.
        hold_mem = 1'b1;
        rd   = 1'b1;
        addr = 32'h284;
        repeat (2) @(negedge clk);
        addr = 32'h0000_0FF0;
        lost    = 0;
        rdy_cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (!mem_en) lost++;
            if (data_rdy) rdy_cnt++;
        end
        chk("stall_en_lost", lost, 32'd0);
        chk("stall_rdy", rdy_cnt, 32'd0);
        chk("stall_addr", mem_addr, 32'h284);
        chk("stall_rw", {31'd0, mem_rw}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_en", {31'd0, mem_en}, 32'd0);
        chk("arst_mem_addr", mem_addr, 32'd0);
        chk("arst_output_data", output_data, 32'd0);
        chk("arst_misc", {29'd0, data_rdy, mem_rw, |wr_to_mem}, 32'd0);
        rd = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        hold_mem = 1'b0;
        @(negedge clk);

        cpu_op(1'b1, 1'b0, 32'h4, 32'd0, 32'hBEEF, lat, rdata);
        chk("postrst_nmem", log_rw.size(), 32'd1);
        chk("postrst_rw", {31'd0, log_rw[0]}, 32'd0);
        chk("postrst_rdata", rdata, 32'hBEEF);

        // rd and wr together: the write wins.
        cpu_op(1'b1, 1'b1, 32'h8, 32'd7, 32'h99, lat, rdata);
        chk("both_addr", log_addr[0], 32'h8);
        chk("both_outdata_kept", output_data, 32'hBEEF);
        cpu_op(1'b1, 1'b0, 32'h8, 32'd0, 32'hBAD, lat, rdata);
        chk("both_rdback", rdata, 32'd7);
        chk("both_rdback_nomem", mem_en_cycles, 32'd0);

        chk("idle_mem_zero", idle_viol, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
